data_bus_demux_4_1: RTL and testbench

- Routes single-initiator data-bus transactions from the core's load/store unit to one of 4 memory-mapped targets (RAM, ROM, GPIO, UART/timer).
- Target is chosen by address bits [SEL_LSB+1:SEL_LSB].
- Tracks the single outstanding transaction and returns the selected target's read data and ack to the initiator.
- Sits between the core's memory stage and the peripheral targets.

---
 rtl/data_bus_pkg.sv | 34 +++
 rtl/data_bus_demux_4_1_timeout.sv | 45 ++++
 rtl/data_bus_demux_4_1.sv | 173 +++++++++++++++++
 tb/tb_data_bus_demux_4_1.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared types and constants for the single-initiator data-bus demultiplexer.
package data_bus_pkg;

    localparam int NUM_TARGETS = 4;
    localparam int SEL_W       = 2;
    localparam int BUS_XLEN    = 32;
    localparam int BUS_ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic                    we;
        logic [BUS_ADDR_W-1:0]   addr;
        logic [BUS_XLEN-1:0]     wdata;
        logic [BUS_XLEN/8-1:0]   be;
    } bus_req_t;

    function automatic logic [NUM_TARGETS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_TARGETS-1:0] onehot;
        case (sel)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/data_bus_demux_4_1_timeout.sv
// bus_timeout_cnt: saturating cycle counter; expired is high while the count
// sits at LIMIT-1. Used by data_bus_demux_4_1 only when DATA_BUS_TIMEOUT_EN is set.
module bus_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          expired_r;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = {CW{1'b0}};
        end else if (en && (cnt_r != LAST)) begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count and expiry flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            expired_r <= (cnt_s == LAST);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/data_bus_demux_4_1.sv
// Routes one outstanding load/store transaction to one of four targets selected
// by m_addr[SEL_LSB+1:SEL_LSB]. Optional target-ack timeout: DATA_BUS_TIMEOUT_EN.
module data_bus_demux_4_1
    import data_bus_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                m_req,
    input  logic                                m_we,
    input  logic [ADDR_W-1:0]                   m_addr,
    input  logic [XLEN-1:0]                     m_wdata,
    input  logic [XLEN/8-1:0]                   m_be,
    output logic                                m_ack,
    output logic [XLEN-1:0]                     m_rdata,
    output logic                                m_err,
    output logic [NUM_TARGETS-1:0]              t_req,
    output logic                                t_we,
    output logic [ADDR_W-1:0]                   t_addr,
    output logic [XLEN-1:0]                     t_wdata,
    output logic [XLEN/8-1:0]                   t_be,
    input  logic [NUM_TARGETS-1:0]              t_ack,
    input  logic [NUM_TARGETS-1:0][XLEN-1:0]    t_rdata
);

    // The latched payload struct is sized by the package widths.
    if ((XLEN != BUS_XLEN) || (ADDR_W != BUS_ADDR_W)) begin : g_bad_width
        $error("data_bus_demux_4_1: XLEN/ADDR_W must match data_bus_pkg widths");
    end
    if (SEL_LSB + 1 >= ADDR_W) begin : g_bad_sel
        $error("data_bus_demux_4_1: select field outside address");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("data_bus_demux_4_1: TIMEOUT_CYCLES must be at least 2");
    end

    bus_state_e             state_r;
    bus_state_e             state_s;
    bus_req_t               req_r;
    logic [SEL_W-1:0]       sel_r;
    logic [NUM_TARGETS-1:0] t_req_r;
    logic [XLEN-1:0]        rdata_r;
    logic                   err_r;
    logic                   m_ack_r;
    logic [XLEN-1:0]        m_rdata_r;
    logic                   m_err_r;
    logic                   accept_s;
    logic                   ack_sel_s;
    logic                   timeout_s;

    // A request still held high during the m_ack cycle belongs to the finished
    // transaction, so IDLE refuses it until m_ack has dropped.
    always_comb begin
        accept_s  = (state_r == IDLE) && m_req && !m_ack_r;
        ack_sel_s = (state_r == BUSY) && t_ack[sel_r];
    end

`ifdef DATA_BUS_TIMEOUT_EN
    logic expired_s;
    logic busy_wait_s;

    // Counter advances only on BUSY cycles with no ack from the selected target.
    always_comb begin
        busy_wait_s = (state_r == BUSY) && !t_ack[sel_r];
        timeout_s   = busy_wait_s && expired_s;
    end

    bus_timeout_cnt #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept_s),
        .en      (busy_wait_s),
        .expired (expired_s)
    );
`else
    // Without the timeout, BUSY waits for the target indefinitely.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = BUSY;
                else          state_s = IDLE;
            end
            BUSY: begin
                if (ack_sel_s || timeout_s) state_s = RESP;
                else                        state_s = BUSY;
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Request capture, target strobe and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r   <= '0;
            sel_r   <= {SEL_W{1'b0}};
            t_req_r <= {NUM_TARGETS{1'b0}};
            rdata_r <= {XLEN{1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_r.we    <= m_we;
                        req_r.addr  <= m_addr;
                        req_r.wdata <= m_wdata;
                        req_r.be    <= m_be;
                        sel_r       <= m_addr[SEL_LSB +: SEL_W];
                        t_req_r     <= sel_onehot(m_addr[SEL_LSB +: SEL_W]);
                        rdata_r     <= {XLEN{1'b0}};
                        err_r       <= 1'b0;
                    end
                end
                BUSY: begin
                    // An ack in the same cycle as the timeout takes priority.
                    if (ack_sel_s) begin
                        t_req_r <= {NUM_TARGETS{1'b0}};
                        rdata_r <= req_r.we ? {XLEN{1'b0}} : t_rdata[sel_r];
                        err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        t_req_r <= {NUM_TARGETS{1'b0}};
                        rdata_r <= {XLEN{1'b0}};
                        err_r   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Initiator response: a single-cycle pulse following the RESP state.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_ack_r   <= 1'b0;
            m_rdata_r <= {XLEN{1'b0}};
            m_err_r   <= 1'b0;
        end else begin
            m_ack_r   <= (state_r == RESP);
            m_rdata_r <= (state_r == RESP) ? rdata_r : {XLEN{1'b0}};
            m_err_r   <= (state_r == RESP) && err_r;
        end
    end

    assign m_ack   = m_ack_r;
    assign m_rdata = m_rdata_r;
    assign m_err   = m_err_r;
    assign t_req   = t_req_r;
    assign t_we    = req_r.we;
    assign t_addr  = req_r.addr;
    assign t_wdata = req_r.wdata;
    assign t_be    = req_r.be;

endmodule

// File: tb/tb_data_bus_demux_4_1.sv
// Self-checking bench for data_bus_demux_4_1: directed table, hand-written
// reset/back-to-back sequences and randomized transactions against a cycle-count model.
module tb_data_bus_demux_4_1;

    logic             clk = 1'b0;
    logic             reset;
    logic             m_req;
    logic             m_we;
    logic [31:0]      m_addr;
    logic [31:0]      m_wdata;
    logic [3:0]       m_be;
    logic             m_ack;
    logic [31:0]      m_rdata;
    logic             m_err;
    logic [3:0]       t_req;
    logic             t_we;
    logic [31:0]      t_addr;
    logic [31:0]      t_wdata;
    logic [3:0]       t_be;
    logic [3:0]       t_ack;
    logic [3:0][31:0] t_rdata;

    int total = 0;
    int bad   = 0;

    // Target responder state.
    int          ack_delay = 0;
    int          busy_cnt  = 0;
    int          cur_sel   = 0;
    logic [31:0] resp_data = 32'h0;
    bit          spur_en   = 1'b0;
    logic [3:0]  force_ack = 4'b0000;
    bit          blocked_pending = 1'b0;

`ifdef DATA_BUS_TIMEOUT_EN
    localparam int TO = 16;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        logic [31:0] rdv;
        logic [3:0]  exp_treq;
        logic [31:0] exp_rd;
        bit          chain;
    } vec_t;

    vec_t vt[6];

    data_bus_demux_4_1 dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_be    (m_be),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .t_req   (t_req),
        .t_we    (t_we),
        .t_addr  (t_addr),
        .t_wdata (t_wdata),
        .t_be    (t_be),
        .t_ack   (t_ack),
        .t_rdata (t_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one edge, then model the targets for the coming cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) t_rdata[i] = $urandom;
        t_rdata[cur_sel] = resp_data;
        t_ack = spur_en ? 4'($urandom_range(0, 15)) : 4'b0000;
        if (t_req == 4'b0000) begin
            busy_cnt = 0;
        end else begin
            t_ack = t_ack & ~t_req;
            if (ack_delay >= 0 && busy_cnt == ack_delay) t_ack = t_ack | t_req;
            busy_cnt++;
        end
        t_ack = t_ack | force_ack;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int delay, input logic [31:0] rdv,
                          input logic [3:0] exp_treq, input logic [31:0] exp_rd, input bit chain);
        int eff;
        bit exp_err;
        eff = delay;
        exp_err = 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
        if (delay < 0 || delay > TO - 1) begin
            eff = TO - 1;
            exp_err = 1'b1;
        end
`endif
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
        ack_delay = delay;
        resp_data = rdv;
        cur_sel   = int'((addr >> 28) & 32'd3);
        if (blocked_pending) begin
            tick();
            chk("b2b_gap_treq", t_req, 4'b0000);
            chk("b2b_gap_ack", m_ack, 1'b0);
            blocked_pending = 1'b0;
        end
        for (int j = 0; j <= eff + 2; j++) begin
            tick();
            chk("treq", t_req, (j <= eff) ? exp_treq : 4'b0000);
            chk("mack", m_ack, (j == eff + 2));
            chk("merr", m_err, (j == eff + 2) && exp_err);
            if (j <= eff) begin
                chk("twe", t_we, we);
                chk("taddr", t_addr, addr);
                chk("twdata", t_wdata, wdata);
                chk("tbe", t_be, be);
            end
            if (j == eff + 2) chk("mrdata", m_rdata, exp_err ? 32'h0 : exp_rd);
            else              chk("mrdata_idle", m_rdata, 32'h0);
        end
        if (chain) begin
            blocked_pending = 1'b1;
        end else begin
            m_req = 1'b0;
            tick();
            chk("post_ack", m_ack, 1'b0);
            chk("post_treq", t_req, 4'b0000);
        end
    endtask

    initial begin
        logic        r_we;
        logic [31:0] r_addr;
        logic [31:0] r_rdv;
        int          r_sel;
        bit          r_chain;

        vt[0] = '{1'b0, 32'h2000_0010, 32'h0,         4'b1111, 0, 32'hDEAD_BEEF, 4'b0100, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011, 4, 32'hCAFE_F00D, 4'b1000, 32'h0,         1'b0};
        vt[2] = '{1'b0, 32'h0000_0100, 32'h0,         4'b1111, 1, 32'h1111_2222, 4'b0001, 32'h1111_2222, 1'b1};
        vt[3] = '{1'b0, 32'h1000_0200, 32'h0,         4'b1111, 0, 32'h3333_4444, 4'b0010, 32'h3333_4444, 1'b0};
        vt[4] = '{1'b0, 32'hF000_FFFC, 32'h0,         4'b1111, 2, 32'hA5A5_5A5A, 4'b1000, 32'hA5A5_5A5A, 1'b0};
        vt[5] = '{1'b1, 32'h4000_0000, 32'h0BAD_F00D, 4'b1100, 3, 32'h7777_8888, 4'b0001, 32'h0,         1'b0};

        reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
        t_ack = 4'b0000; t_rdata = '0;

        // Reset and idle.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_treq", t_req, 4'b0000);
            chk("rst_ack", m_ack, 1'b0);
            chk("rst_taddr", t_addr, 32'h0);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_treq", t_req, 4'b0000);
            chk("idle_ack", m_ack, 1'b0);
            chk("idle_rdata", m_rdata, 32'h0);
            chk("idle_err", m_err, 1'b0);
        end

        // Directed table; spurious acks on other targets from vector 1 on.
        for (int v = 0; v < 6; v++) begin
            spur_en = (v != 0);
            do_txn(vt[v].we, vt[v].addr, vt[v].wdata, vt[v].be, vt[v].delay, vt[v].rdv,
                   vt[v].exp_treq, vt[v].exp_rd, vt[v].chain);
        end
        spur_en = 1'b0;

        // Reset while BUSY on target 1, coinciding with its ack and followed by more acks.
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0000; m_be = 4'hF;
        ack_delay = 2; cur_sel = 1; resp_data = 32'h5555_6666;
        tick();
        tick();
        chk("rst_mid_treq", t_req, 4'b0010);
        tick();
        reset = 1'b1; m_req = 1'b0; force_ack = 4'b0010;
        tick();
        chk("rst_mid_treq_clr", t_req, 4'b0000);
        chk("rst_mid_ack", m_ack, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_after_ack", m_ack, 1'b0);
            chk("rst_after_treq", t_req, 4'b0000);
        end
        force_ack = 4'b0000;
        do_txn(1'b0, 32'h2000_0000, 32'h0, 4'hF, 1, 32'h0F0F_0F0F, 4'b0100, 32'h0F0F_0F0F, 1'b0);

`ifdef DATA_BUS_TIMEOUT_EN
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, -1, 32'h9999_9999, 4'b0001, 32'h0,         1'b0);
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 15, 32'h8888_1111, 4'b0001, 32'h8888_1111, 1'b0);
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 16, 32'h8888_2222, 4'b0001, 32'h0,         1'b0);
`endif

        // Randomized transactions checked against the transaction-level model.
        spur_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_rdv   = $urandom;
            r_sel   = int'((r_addr >> 28) % 4);
            r_chain = (n != 39) && ($urandom_range(0, 2) == 0);
            do_txn(r_we, r_addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 5),
                   r_rdv, 4'(1 << r_sel), r_we ? 32'h0 : r_rdv, r_chain);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
